// File: rtl/text_buffer_pkg.sv
// Shared constants and types for the 80x25 text-mode character/attribute buffer.
package pisa_video_pkg;

    localparam int unsigned COLS         = 80;
    localparam int unsigned ROWS         = 25;
    localparam int unsigned CELLS        = COLS * ROWS;
    localparam int unsigned ADDR_W       = 12;
    localparam int unsigned RAM_AW       = 11;
    localparam int unsigned BLINK_FRAMES = 16;

    typedef struct packed {
        logic [7:0] ch;
        logic [3:0] bg;
        logic [3:0] fg;
    } cell_t;

    localparam cell_t CLEAR_CELL = 16'h2007;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } tb_state_t;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return a < ADDR_W'(CELLS);
    endfunction

endpackage

// File: rtl/text_ram.sv
// True dual-port RAM, read-before-write, array read register plus one output stage per port.
module text_ram #(
    parameter int unsigned AW = 11,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic [AW-1:0] i_a_addr,
    output logic [DW-1:0] o_a_q,
    input  logic [AW-1:0] i_b_addr,
    input  logic          i_b_we,
    input  logic [DW-1:0] i_b_wdata,
    output logic [DW-1:0] o_b_q
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_a_rd;
    logic [DW-1:0] r_b_rd;

    always_ff @(posedge clk) begin
        r_a_rd <= r_mem[i_a_addr];
        o_a_q  <= r_a_rd;
    end

    always_ff @(posedge clk) begin
        if (i_b_we)
            r_mem[i_b_addr] <= i_b_wdata;
        r_b_rd <= r_mem[i_b_addr];
        o_b_q  <= r_b_rd;
    end

endmodule

// File: rtl/text_buffer.sv
// Text-mode cell store: display read port, CPU bus port, clear-screen engine, blinking cursor.
module text_buffer
    import pisa_video_pkg::*;
(
    input  logic        clk_pixel,
    input  logic        rst_n,
    input  logic [11:0] video_address,
    output logic [7:0]  active_char,
    output logic [3:0]  active_foreground,
    output logic [3:0]  active_background,
    input  logic        vsync,
    input  logic        bus_valid,
    output logic        bus_ready,
    input  logic        bus_write,
    input  logic [11:0] bus_addr,
    input  logic [15:0] bus_wdata,
    output logic [15:0] bus_rdata,
    output logic        bus_rvalid,
    input  logic        clear_req,
    output logic        clear_busy,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_x,
    input  logic [4:0]  cursor_y
);

    tb_state_t         r_state;
    logic [RAM_AW-1:0] r_clr_idx;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [3:0]        r_blink_cnt;
    logic              r_blink_phase;
    logic              r_vs;
    logic              r_vs_d;
    logic              r_v_ok1, r_v_ok2;
    logic              r_v_hit1, r_v_hit2;
    logic              r_rd1, r_rd2;
    logic              r_rd_ok1, r_rd_ok2;

    logic              w_accept;
    logic [RAM_AW-1:0] w_b_addr;
    logic              w_b_we;
    logic [15:0]       w_b_wdata;
    logic [15:0]       w_a_q;
    logic [15:0]       w_b_q;
    cell_t             w_a_cell;
    logic [ADDR_W-1:0] w_cur_y;

    assign w_accept = bus_valid & bus_ready;
    assign w_a_cell = cell_t'(w_a_q);
    assign w_cur_y  = ADDR_W'(cursor_y);

    // Port B belongs to the clear engine while clearing; no writes land on a reset edge.
    always_comb begin
        w_b_addr  = bus_addr[RAM_AW-1:0];
        w_b_we    = rst_n & w_accept & bus_write & in_range(bus_addr);
        w_b_wdata = bus_wdata;
        if (r_state == ST_CLEAR) begin
            w_b_addr  = r_clr_idx;
            w_b_we    = rst_n;
            w_b_wdata = CLEAR_CELL;
        end
    end

    text_ram #(
        .AW (RAM_AW),
        .DW (16)
    ) u_ram (
        .clk       (clk_pixel),
        .i_a_addr  (video_address[RAM_AW-1:0]),
        .o_a_q     (w_a_q),
        .i_b_addr  (w_b_addr),
        .i_b_we    (w_b_we),
        .i_b_wdata (w_b_wdata),
        .o_b_q     (w_b_q)
    );

    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_clr_idx  <= '0;
            bus_ready  <= 1'b0;
            clear_busy <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clear_req) begin
                        r_state    <= ST_CLEAR;
                        r_clr_idx  <= '0;
                        bus_ready  <= 1'b0;
                        clear_busy <= 1'b1;
                    end else begin
                        bus_ready  <= 1'b1;
                        clear_busy <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_idx == RAM_AW'(CELLS - 1)) begin
                        r_state    <= ST_IDLE;
                        bus_ready  <= 1'b1;
                        clear_busy <= 1'b0;
                    end else begin
                        r_clr_idx <= r_clr_idx + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            r_cur_addr    <= '0;
            r_vs          <= 1'b0;
            r_vs_d        <= 1'b0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_cur_addr <= (w_cur_y << 6) + (w_cur_y << 4) + ADDR_W'(cursor_x);
            r_vs       <= vsync;
            r_vs_d     <= r_vs;
            if (r_vs && !r_vs_d) begin
                if (r_blink_cnt == 4'(BLINK_FRAMES - 1)) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    // Range and cursor flags travel alongside the two RAM stages to meet the data.
    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            r_v_ok1           <= 1'b0;
            r_v_ok2           <= 1'b0;
            r_v_hit1          <= 1'b0;
            r_v_hit2          <= 1'b0;
            r_rd1             <= 1'b0;
            r_rd2             <= 1'b0;
            r_rd_ok1          <= 1'b0;
            r_rd_ok2          <= 1'b0;
            active_char       <= '0;
            active_foreground <= '0;
            active_background <= '0;
            bus_rdata         <= '0;
            bus_rvalid        <= 1'b0;
        end else begin
            r_v_ok1  <= in_range(video_address);
            r_v_hit1 <= cursor_en & r_blink_phase & (video_address == r_cur_addr);
            r_v_ok2  <= r_v_ok1;
            r_v_hit2 <= r_v_hit1;
            if (r_v_ok2) begin
                active_char       <= w_a_cell.ch;
                active_foreground <= r_v_hit2 ? w_a_cell.bg : w_a_cell.fg;
                active_background <= r_v_hit2 ? w_a_cell.fg : w_a_cell.bg;
            end else begin
                active_char       <= '0;
                active_foreground <= '0;
                active_background <= '0;
            end

            r_rd1      <= w_accept & ~bus_write;
            r_rd_ok1   <= in_range(bus_addr);
            r_rd2      <= r_rd1;
            r_rd_ok2   <= r_rd_ok1;
            bus_rvalid <= r_rd2;
            if (r_rd2)
                bus_rdata <= r_rd_ok2 ? w_b_q : '0;
        end
    end

endmodule

// File: tb/tb_text_buffer.sv
// Directed-plus-random bench for text_buffer against a cell-array reference model.
module tb_text_buffer;

    logic        clk_pixel = 1'b0;
    logic        rst_n;
    logic [11:0] video_address;
    logic [7:0]  active_char;
    logic [3:0]  active_foreground;
    logic [3:0]  active_background;
    logic        vsync;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_write;
    logic [11:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_rvalid;
    logic        clear_req;
    logic        clear_busy;
    logic        cursor_en;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;

    text_buffer dut (
        .clk_pixel         (clk_pixel),
        .rst_n             (rst_n),
        .video_address     (video_address),
        .active_char       (active_char),
        .active_foreground (active_foreground),
        .active_background (active_background),
        .vsync             (vsync),
        .bus_valid         (bus_valid),
        .bus_ready         (bus_ready),
        .bus_write         (bus_write),
        .bus_addr          (bus_addr),
        .bus_wdata         (bus_wdata),
        .bus_rdata         (bus_rdata),
        .bus_rvalid        (bus_rvalid),
        .clear_req         (clear_req),
        .clear_busy        (clear_busy),
        .cursor_en         (cursor_en),
        .cursor_x          (cursor_x),
        .cursor_y          (cursor_y)
    );

    always #5 clk_pixel = ~clk_pixel;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          total = 0;
    int          bad   = 0;
    logic [15:0] mem   [0:2047];
    bit          known [0:2047];
    int          rises = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_pixel);
        #1;
    endtask

    function automatic logic [15:0] exp_disp(input int a);
        logic [15:0] c;
        if (a >= 2000) return 16'h0000;
        c = mem[a];
        if (cursor_en && ((rises / 16) % 2 == 1) && a == int'(cursor_y) * 80 + int'(cursor_x))
            c = {c[15:8], c[3:0], c[7:4]};
        return c;
    endfunction

    function automatic int pick_addr();
        int a;
        if ($urandom_range(0, 7) == 0) return $urandom_range(2000, 4095);
        repeat (200) begin
            a = $urandom_range(0, 1999);
            if (known[a]) return a;
        end
        return 85;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (bus_ready !== 1'b1 && n < 3000) begin
            step();
            n++;
        end
        if (bus_ready !== 1'b1) chk("ready_timeout", {31'd0, bus_ready}, 32'd1);
    endtask

    task automatic bus_wr(input int a, input logic [15:0] d);
        wait_ready();
        bus_valid = 1'b1; bus_write = 1'b1; bus_addr = 12'(a); bus_wdata = d;
        step();
        bus_valid = 1'b0; bus_write = 1'b0;
        if (a < 2000) begin
            mem[a]   = d;
            known[a] = 1'b1;
        end
    endtask

    task automatic bus_rd(input string tag, input int a);
        logic [15:0] e;
        e = (a < 2000) ? mem[a] : 16'h0000;
        wait_ready();
        bus_valid = 1'b1; bus_write = 1'b0; bus_addr = 12'(a);
        step();
        bus_valid = 1'b0;
        step();
        chk({tag, "_rvalid_early"}, {31'd0, bus_rvalid}, 32'd0);
        step();
        chk({tag, "_rvalid"}, {31'd0, bus_rvalid}, 32'd1);
        chk({tag, "_rdata"}, {16'd0, bus_rdata}, {16'd0, e});
        step();
        chk({tag, "_rvalid_pulse"}, {31'd0, bus_rvalid}, 32'd0);
    endtask

    task automatic disp_one(input string tag, input int a);
        video_address = 12'(a);
        step(); step(); step();
        chk(tag, {16'd0, active_char, active_background, active_foreground}, {16'd0, exp_disp(a)});
    endtask

    task automatic disp_stream(input string tag, input int n, input int hot);
        int q [$];
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                q.push_back(($urandom_range(0, 3) == 0) ? hot : pick_addr());
                video_address = 12'(q[i]);
            end
            step();
            if (i >= 2)
                chk(tag, {16'd0, active_char, active_background, active_foreground},
                    {16'd0, exp_disp(q[i-2])});
        end
    endtask

    task automatic pulse_vsync(input int n);
        repeat (n) begin
            vsync = 1'b1; step();
            vsync = 1'b0; step();
            rises++;
        end
        step(); step(); step();
    endtask

    int          ba [16];
    logic [15:0] bd [16];
    logic [15:0] bexp [16];
    int          busy_cyc;
    int          nrv;
    int          ca;
    logic [15:0] v, exp85;

    initial begin
        rst_n = 1'b0; video_address = '0; vsync = 1'b0; bus_valid = 1'b0; bus_write = 1'b0;
        bus_addr = '0; bus_wdata = '0; clear_req = 1'b0; cursor_en = 1'b0; cursor_x = '0; cursor_y = '0;
        for (int i = 0; i < 2048; i++) begin
            mem[i]   = 16'h0000;
            known[i] = 1'b0;
        end

        step(); step();
        chk("rst_ready", {31'd0, bus_ready}, 32'd0);
        chk("rst_busy", {31'd0, clear_busy}, 32'd0);
        chk("rst_rvalid", {31'd0, bus_rvalid}, 32'd0);
        chk("rst_rdata", {16'd0, bus_rdata}, 32'd0);
        chk("rst_disp", {16'd0, active_char, active_background, active_foreground}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", {31'd0, bus_ready}, 32'd1);

        bus_wr(85, 16'h411E);
        disp_one("disp_85", 85);
        chk("disp_85_lit", {16'd0, active_char, active_background, active_foreground}, 32'h411E);
        disp_one("disp_2000", 2000);
        foreach (ba[i]) bus_wr(i == 0 ? 0 : i == 1 ? 79 : i == 2 ? 80 : i == 3 ? 1999 : $urandom_range(0, 1999),
                               16'($urandom));
        repeat (32) bus_wr($urandom_range(0, 1999), 16'($urandom));
        disp_stream("disp_stream", 40, 85);

        bus_rd("rd_85", 85);
        bus_rd("rd_4000", 4000);
        bus_rd("rd_1999", 1999);
        bus_wr(2133, 16'hDEAD);
        bus_wr(4095, 16'hBEEF);
        bus_rd("rd_85_after_oob_wr", 85);

        // write and display of the same cell in one cycle: display sees the old value
        bus_wr(300, 16'h1234);
        wait_ready();
        video_address = 12'd300;
        bus_valid = 1'b1; bus_write = 1'b1; bus_addr = 12'd300; bus_wdata = 16'hABCD;
        step();
        bus_valid = 1'b0; bus_write = 1'b0; video_address = 12'd2000;
        step(); step();
        chk("collide_old", {16'd0, active_char, active_background, active_foreground}, 32'h1234);
        mem[300] = 16'hABCD;
        bus_rd("collide_new", 300);

        wait_ready();
        for (int i = 0; i < 16; i++) begin
            ba[i] = (i == 15) ? 4000 : $urandom_range(0, 1999);
            bd[i] = 16'($urandom);
            bus_valid = 1'b1; bus_write = 1'b1; bus_addr = 12'(ba[i]); bus_wdata = bd[i];
            chk("burst_wr_ready", {31'd0, bus_ready}, 32'd1);
            step();
            if (ba[i] < 2000) begin
                mem[ba[i]]   = bd[i];
                known[ba[i]] = 1'b1;
            end
        end
        for (int i = 0; i < 16; i++) bexp[i] = (ba[i] < 2000) ? mem[ba[i]] : 16'h0000;
        for (int i = 0; i < 19; i++) begin
            if (i < 16) begin
                bus_valid = 1'b1; bus_write = 1'b0; bus_addr = 12'(ba[i]);
                chk("burst_rd_ready", {31'd0, bus_ready}, 32'd1);
            end else begin
                bus_valid = 1'b0;
            end
            step();
            if (i >= 2 && i < 18) begin
                chk("burst_rvalid", {31'd0, bus_rvalid}, 32'd1);
                chk("burst_rdata", {16'd0, bus_rdata}, {16'd0, bexp[i-2]});
            end else begin
                chk("burst_rvalid_idle", {31'd0, bus_rvalid}, 32'd0);
            end
        end

        wait_ready();
        exp85 = mem[85];
        video_address = 12'd2000;
        clear_req = 1'b1; bus_valid = 1'b1; bus_write = 1'b0; bus_addr = 12'd85;
        step();
        clear_req = 1'b0; bus_addr = 12'd1999;
        chk("clr_busy_start", {31'd0, clear_busy}, 32'd1);
        chk("clr_ready_low", {31'd0, bus_ready}, 32'd0);
        busy_cyc = 1;
        nrv = 0;
        for (int k = 0; k < 2100; k++) begin
            step();
            if (k == 5) clear_req = 1'b1;
            if (k == 6) clear_req = 1'b0;
            if (bus_rvalid) begin
                nrv++;
                if (nrv == 1) chk("clr_pre_read", {16'd0, bus_rdata}, {16'd0, exp85});
            end
            if (!clear_busy) break;
            busy_cyc++;
        end
        chk("clr_busy_cycles", busy_cyc, 2000);
        chk("clr_reads_during", nrv, 1);
        chk("clr_ready_back", {31'd0, bus_ready}, 32'd1);
        for (int i = 0; i < 2000; i++) begin
            mem[i]   = 16'h2007;
            known[i] = 1'b1;
        end
        step();
        bus_valid = 1'b0;
        chk("clr_held_rv0", {31'd0, bus_rvalid}, 32'd0);
        step();
        chk("clr_held_rv1", {31'd0, bus_rvalid}, 32'd0);
        step();
        chk("clr_held_rvalid", {31'd0, bus_rvalid}, 32'd1);
        chk("clr_held_rdata", {16'd0, bus_rdata}, 32'h2007);
        step();
        chk("clr_no_restart", {31'd0, clear_busy}, 32'd0);
        bus_rd("clr_rd_0", 0);
        bus_rd("clr_rd_85", 85);
        bus_rd("clr_rd_1999", 1999);

        bus_wr(85, 16'h411E);
        cursor_x = 7'd5; cursor_y = 5'd1; cursor_en = 1'b1;
        step();
        disp_one("cur_phase0", 85);
        pulse_vsync(16);
        disp_one("cur_swap", 85);
        chk("cur_swap_lit", {16'd0, active_char, active_background, active_foreground}, 32'h41E1);
        disp_stream("cur_stream", 30, 85);
        pulse_vsync(16);
        disp_one("cur_revert", 85);
        pulse_vsync(16);
        cursor_en = 1'b0;
        step();
        disp_one("cur_disabled", 85);
        cursor_en = 1'b1;
        repeat (8) begin
            cursor_x = 7'($urandom_range(0, 127));
            cursor_y = 5'($urandom_range(0, 31));
            ca = int'(cursor_y) * 80 + int'(cursor_x);
            if (ca < 2000) bus_wr(ca, 16'($urandom));
            else step();
            disp_one("cur_rand", ca);
            if (ca + 1 < 2000) disp_one("cur_rand_next", ca + 1);
        end
        cursor_x = 7'd79; cursor_y = 5'd24;
        step();
        bus_wr(1999, 16'h5A3C);
        disp_one("cur_last_cell", 1999);

        v = 16'($urandom) | 16'h8000;
        bus_wr(500, v);
        v = 16'($urandom) | 16'h8000;
        bus_wr(1500, v);
        wait_ready();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (1000) step();
        rst_n = 1'b0;
        step();
        chk("midrst_busy", {31'd0, clear_busy}, 32'd0);
        chk("midrst_ready", {31'd0, bus_ready}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("midrst_ready_back", {31'd0, bus_ready}, 32'd1);
        for (int i = 0; i < 1000; i++) mem[i] = 16'h2007;
        known[1000] = 1'b0;
        rises = 0;
        bus_rd("midrst_500", 500);
        bus_rd("midrst_999", 999);
        bus_rd("midrst_1500", 1500);
        cursor_x = 7'd5; cursor_y = 5'd1;
        bus_wr(85, 16'h411E);
        disp_one("midrst_blink_reset", 85);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/text_buffer.md
Name: text_buffer

Overview:
- Character/attribute store for 80x25 text mode. Sits directly upstream of the VGA text renderer.
- Display side: answers the renderer's `video_address` with `active_char`, `active_foreground` and `active_background` at a fixed 2-cycle latency.
- Bus side: a valid/ready CPU port for cell reads and writes.
- Also provides a hardware clear-screen engine and a blinking hardware cursor.

Parameters:
- COLS, 80, text columns
- ROWS, 25, text rows
- CELLS, COLS*ROWS (2000), valid cell addresses
- ADDR_W, 12, address width (matches `video_address`)
- BLINK_FRAMES, 16, frames per cursor blink phase
- CLEAR_CELL, 16'h2007, fill value for clear (space, bg 0, fg 7)

Ports:
- clk_pixel  in  1  pixel clock, sole clock
- rst_n  in  1  synchronous, active-low reset
- video_address  in  12  display read address from renderer
- active_char  out  8  character code for display read
- active_foreground  out  4  fg palette index
- active_background  out  4  bg palette index
- vsync  in  1  renderer vsync (high during sync pulse)
- bus_valid  in  1  CPU request valid
- bus_ready  out  1  CPU request may be accepted
- bus_write  in  1  1=write, 0=read
- bus_addr  in  12  cell address
- bus_wdata  in  16  cell data {char[15:8], bg[7:4], fg[3:0]}
- bus_rdata  out  16  read data
- bus_rvalid  out  1  read data valid pulse
- clear_req  in  1  start clear-screen (pulse)
- clear_busy  out  1  clear in progress
- cursor_en  in  1  cursor enable
- cursor_x  in  7  cursor column
- cursor_y  in  5  cursor row

Behaviour:
- Reset (rst_n low at posedge): all outputs 0, FSM=IDLE, blink counter/phase 0. RAM contents are not reset. `bus_ready` goes 1 on the first edge with rst_n high.
- Cell format is 16 bits: [15:8] char, [7:4] bg, [3:0] fg.
- Storage: 2048x16 dual-port block RAM. Port A is display read-only; port B is bus/clear read-write.
- Display latency: `video_address` sampled at edge N gives outputs valid after edge N+2, exactly, every cycle, with no stalls.
  - Address >= CELLS gives char 0, fg 0, bg 0.
  - Addresses past column 79 are plain linear addresses (spill to the next row). No special handling.
- Cursor:
  - `cur_addr = cursor_y*80 + cursor_x`, registered, computed with shift-add in 12 bits.
  - When `cursor_en` && `blink_phase` && the display address equals `cur_addr`: fg and bg are swapped on output for that cell.
  - Cursor at an address >= CELLS never matches.
- Blink:
  - Rising edge of `vsync` (registered compare) increments the frame counter.
  - At BLINK_FRAMES-1 the counter wraps to 0 and `blink_phase` toggles.
- Bus:
  - Transfer occurs on an edge with `bus_valid` && `bus_ready`.
  - `bus_ready` = (state==IDLE), registered, and 0 in reset.
  - Write to addr < CELLS updates the RAM. Write to addr >= CELLS is accepted and dropped.
  - Read: `bus_rvalid` pulses one cycle, 2 edges after acceptance, with `bus_rdata`. Out-of-range read returns 0. `bus_rdata` holds its value between pulses.
  - Back-to-back transfers are accepted at one per cycle.
  - Bus write and display read of the same address in the same cycle: display returns the old data.
- Clear FSM, states IDLE and CLEAR:
  - IDLE to CLEAR on `clear_req`. `clear_busy` and `!bus_ready` are asserted from the next edge.
  - CLEAR writes CLEAR_CELL to index 0..CELLS-1, one per cycle (2000 cycles). After index CELLS-1, state returns to IDLE.
  - `clear_req` during CLEAR is ignored.
  - `clear_req` with an accepted bus transfer in the same cycle: the transfer completes, including read data return, then the clear starts.
  - The display keeps reading throughout and may show a partially cleared screen.
  - Reset mid-clear: state returns to IDLE and the RAM stays partially cleared.

Decomposition:
- Package `pisa_video_pkg`:
  - COLS, ROWS, CELLS
  - packed struct `cell_t` {char, bg, fg}
  - CLEAR_CELL
  - FSM enum `tb_state_t`
- Sub-module `text_ram`: inferred true dual-port 2048x16 RAM with read-before-write and one registered output stage per port.
- `text_buffer` contains the address checks, cursor/blink logic, clear FSM and bus handshake.

Test Plan:
- Reset, then bus write addr 85 data 16'h41_1E, then drive `video_address`=85 -> after exactly 2 edges `active_char`=8'h41, bg=1, fg=E; `video_address`=2000 -> all outputs 0.
- Bus read addr 85 right after the write -> `bus_rvalid` one cycle, 2 edges after acceptance, `bus_rdata`=16'h411E; read addr 4000 -> `bus_rdata`=0.
- Pulse `clear_req` -> `clear_busy` high 2000 cycles and `bus_ready` low. Afterwards reads of addr 0, 85 and 1999 return 16'h2007, and a `bus_valid` held during the clear is accepted only after `clear_busy` falls.
- Cursor at (5,1), addr 85, with `cursor_en`=1 -> after 16 `vsync` rising edges, display of addr 85 shows fg=1, bg=E. After 16 more it reverts. With `cursor_en`=0 it never swaps.
- Assert rst_n low at clear index 1000 -> next edge `clear_busy`=0, `bus_ready`=0. Index 500 reads 16'h2007 and index 1500 keeps its old data.
- Stream 16 consecutive writes then reads at one per cycle -> all accepted, read data returned in order, one `bus_rvalid` per read.
